mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares one single-port instruction/data memory between the IF-stage fetch requester and the EX/WB-stage load/store requester.
- Arbitrates between the two requesters and holds one memory transaction outstanding at a time.
- Routes each response back to the requester that issued it.
- Flags misaligned fetches and memory timeouts as error responses, which the pipeline's exception logic consumes.
- Sits between the pipeline's memory interfaces and the memory model or bus.

Parameters:
TIMEOUT, 64, cycles allowed from mem_req assertion to mem_valid before an error response is generated (range 2..255)
DATA_STREAK_MAX, 4, consecutive data grants allowed while inst_req is pending before inst is forced (range 1..15)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
inst_req  in  1  fetch request; held with inst_addr until inst_ready
inst_addr  in  32  fetch byte address
inst_ready  out  1  1-cycle pulse: fetch request accepted
inst_valid  out  1  1-cycle pulse: fetch response
inst_rdata  out  32  fetch data; valid with inst_valid, 0 on error
inst_err  out  1  with inst_valid: misaligned or timeout
data_req  in  1  load/store request; held with its fields until data_ready
data_we  in  1  1 = store
data_addr  in  32  data byte address
data_wdata  in  32  store data
data_wstrb  in  4  store byte enables
data_ready  out  1  1-cycle pulse: data request accepted
data_valid  out  1  1-cycle pulse: data response (loads and stores)
data_rdata  out  32  load data, 0 for stores and errors
data_err  out  1  with data_valid: timeout
mem_req  out  1  memory request, held until mem_ready
mem_we, mem_addr[31:0], mem_wdata[31:0], mem_wstrb[3:0]  out  -  registered request fields, stable while mem_req is high
mem_ready  in  1  memory accepts the request this cycle
mem_valid  in  1  memory response this cycle
mem_rdata  in  32  memory read data

Behaviour:
- Reset: every output is 0. FSM enters IDLE. Owner, streak counter, timer and orphan flag are cleared. Reset aborts an in-flight transaction with no response; the memory is reset alongside.
- FSM states: IDLE -> ISSUE -> WAIT -> IDLE.
- IDLE arbitration, cycle N:
  - Data wins over inst, except inst wins when inst_req=1 and streak==DATA_STREAK_MAX.
  - The winner gets its *_ready pulse at N. Its fields are latched into mem_* and owner is recorded. mem_req=1 from N+1; FSM moves to ISSUE.
- Misaligned fetch (inst_addr[1:0]!=0) on an inst grant:
  - inst_ready at N, inst_valid=1 and inst_err=1 at N+1.
  - No memory access; FSM stays in IDLE.
  - The data side may be granted at N+1.
- Streak counter:
  - Increments, saturating, on each data grant made while inst_req=1.
  - Clears on any inst grant, and whenever inst_req=0 in IDLE.
- ISSUE: mem_req held high. When mem_ready=1, mem_req drops next cycle and FSM moves to WAIT. mem_valid is accepted in the same cycle as mem_ready (zero-latency memory); FSM then goes straight to response.
- WAIT: on mem_valid, the owner's *_valid pulses for 1 cycle.
  - *_rdata = mem_rdata for reads, 0 for stores; *_err=0.
  - FSM returns to IDLE in that same cycle, so the earliest next mem_req is 2 cycles after the mem_valid cycle.
- Timeout:
  - The timer starts at 0 when ISSUE is entered and counts in ISSUE and WAIT.
  - At TIMEOUT-1 with no mem_valid: owner gets *_valid=1, *_err=1, *_rdata=0 next cycle. mem_req drops, FSM goes to IDLE.
  - If the timeout fired in WAIT, orphan is set.
- Orphan: while orphan=1, the first mem_valid is discarded and clears orphan. New grants are blocked while orphan=1.
- Simultaneous events:
  - The response-cycle *_valid and a new *_ready to the same requester never occur in the same cycle.
  - inst_valid and data_valid are never high together.
- Requester rules:
  - Dropping *_req before *_ready is illegal; the bench asserts on it.
  - Fields are sampled only in the grant cycle.

Decomposition:
- Shared package (mem_arb_pkg): FSM state encoding (IDLE, ISSUE, WAIT), owner encoding (OWN_INST, OWN_DATA), default TIMEOUT and DATA_STREAK_MAX.
- One natural sub-module: mem_arb_timer, holding the TIMEOUT counter with start/clear/expired.
- Arbitration, streak counter and FSM stay in the top level.

Test Plan:
- Single fetch: inst_req, addr 0x100, mem_ready immediate, mem_valid 3 cycles later with 0x00000013 -> inst_ready at N, mem_req N+1..N+1, inst_valid with rdata 0x00000013 and inst_err=0.
- Contention: inst_req and data_req (load 0x2000) both high in the same cycle -> data granted first, inst granted in the IDLE cycle after data_valid. With data_req held continuously, inst is forced after exactly 4 data grants.
- Store: data_we=1, addr 0x3004, wdata 0xDEADBEEF, wstrb 0xF -> mem_we=1 with the exact fields, data_valid with data_rdata=0.
- Misaligned fetch at 0x102 -> inst_ready, then inst_valid+inst_err next cycle, mem_req never asserted.
- Timeout: TIMEOUT=8, memory never asserts mem_valid -> err response 8 cycles after ISSUE entry. A late mem_valid is dropped (orphan) and no spurious *_valid appears.
- Reset asserted in WAIT -> all outputs 0 asynchronously. After release, a fresh fetch completes normally.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the instruction/data memory port arbiter.
// Holds the FSM and owner encodings plus the address-alignment helper.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_e;

    localparam int DEF_TIMEOUT         = 64;
    localparam int DEF_DATA_STREAK_MAX = 4;
    localparam int TIMER_W             = 8;
    localparam int STREAK_W            = 4;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// Transaction timeout counter: cleared while idle, counts while a memory
// transaction is open, and flags the last allowed cycle.
module mem_arb_timer
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_run,
    output logic o_expired
);

    localparam logic [TIMER_W-1:0] LAST = TIMER_W'(TIMEOUT - 1);

    logic [TIMER_W-1:0] r_count;

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the values from before the edge, independent of block order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_run && (r_count != LAST)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = i_run && (r_count == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the fetch and load/store requesters,
// one transaction outstanding, with misalignment and timeout error responses.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT         = DEF_TIMEOUT,
    parameter int DATA_STREAK_MAX = DEF_DATA_STREAK_MAX
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_ready,
    output logic        inst_valid,
    output logic [31:0] inst_rdata,
    output logic        inst_err,
    input  logic        data_req,
    input  logic        data_we,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    input  logic [3:0]  data_wstrb,
    output logic        data_ready,
    output logic        data_valid,
    output logic [31:0] data_rdata,
    output logic        data_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic        mem_valid,
    input  logic [31:0] mem_rdata
);

    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(DATA_STREAK_MAX);

    state_e                r_state;
    state_e                w_next_state;
    owner_e                r_owner;
    owner_e                r_err_owner;
    logic                  r_err_pend;
    logic                  r_orphan;
    logic [STREAK_W-1:0]   r_streak;
    logic                  r_mem_we;
    logic [31:0]           r_mem_addr;
    logic [31:0]           r_mem_wdata;
    logic [3:0]            r_mem_wstrb;

    logic w_arb_en;
    logic w_inst_ok;
    logic w_data_ok;
    logic w_grant_inst;
    logic w_grant_data;
    logic w_mis;
    logic w_resp_mem;
    logic w_timeout;
    logic w_set_orphan;
    logic w_expired;
    logic w_timer_clear;

    assign w_timer_clear = (r_state == ST_IDLE);

    mem_arb_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (w_timer_clear),
        .i_run     (!w_timer_clear),
        .o_expired (w_expired)
    );

    // A requester whose error response is being delivered this cycle is not
    // granted again until the next cycle.
    always_comb begin
        w_arb_en     = (r_state == ST_IDLE) && !r_orphan && !reset;
        w_inst_ok    = inst_req && !(r_err_pend && (r_err_owner == OWN_INST));
        w_data_ok    = data_req && !(r_err_pend && (r_err_owner == OWN_DATA));
        w_grant_data = w_arb_en && w_data_ok && !(w_inst_ok && (r_streak == STREAK_MAX));
        w_grant_inst = w_arb_en && w_inst_ok && !w_grant_data;
        w_mis        = is_misaligned(inst_addr);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every signal written here gets a default first, so no branch can
    // leave one unassigned and infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_resp_mem   = 1'b0;
        w_timeout    = 1'b0;
        w_set_orphan = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if ((w_grant_inst && !w_mis) || w_grant_data) begin
                    w_next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (mem_ready && mem_valid) begin
                    w_resp_mem   = 1'b1;
                    w_next_state = ST_IDLE;
                end else if (w_expired) begin
                    w_timeout    = 1'b1;
                    w_set_orphan = mem_ready;
                    w_next_state = ST_IDLE;
                end else if (mem_ready) begin
                    w_next_state = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_valid) begin
                    w_resp_mem   = 1'b1;
                    w_next_state = ST_IDLE;
                end else if (w_expired) begin
                    w_timeout    = 1'b1;
                    w_set_orphan = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase

        inst_ready = w_grant_inst;
        data_ready = w_grant_data;
        mem_req    = (r_state == ST_ISSUE);
        mem_we     = r_mem_we;
        mem_addr   = r_mem_addr;
        mem_wdata  = r_mem_wdata;
        mem_wstrb  = r_mem_wstrb;

        inst_err   = r_err_pend && (r_err_owner == OWN_INST);
        data_err   = r_err_pend && (r_err_owner == OWN_DATA);
        inst_valid = (w_resp_mem && (r_owner == OWN_INST)) || inst_err;
        data_valid = (w_resp_mem && (r_owner == OWN_DATA)) || data_err;
        inst_rdata = (w_resp_mem && (r_owner == OWN_INST)) ? mem_rdata : '0;
        data_rdata = (w_resp_mem && (r_owner == OWN_DATA) && !r_mem_we) ? mem_rdata : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_owner     <= OWN_INST;
            r_err_owner <= OWN_INST;
            r_err_pend  <= 1'b0;
            r_orphan    <= 1'b0;
            r_streak    <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_wstrb <= '0;
        end else begin
            r_err_pend <= 1'b0;

            if (w_grant_inst) begin
                r_owner  <= OWN_INST;
                r_streak <= '0;
                if (w_mis) begin
                    r_err_pend  <= 1'b1;
                    r_err_owner <= OWN_INST;
                end else begin
                    r_mem_we    <= 1'b0;
                    r_mem_addr  <= inst_addr;
                    r_mem_wdata <= '0;
                    r_mem_wstrb <= '0;
                end
            end else if (w_grant_data) begin
                r_owner     <= OWN_DATA;
                r_mem_we    <= data_we;
                r_mem_addr  <= data_addr;
                r_mem_wdata <= data_wdata;
                r_mem_wstrb <= data_wstrb;
                if (!inst_req) begin
                    r_streak <= '0;
                end else if (r_streak != STREAK_MAX) begin
                    r_streak <= r_streak + 1'b1;
                end
            end else if ((r_state == ST_IDLE) && !inst_req) begin
                r_streak <= '0;
            end

            if (w_timeout) begin
                r_err_pend  <= 1'b1;
                r_err_owner <= r_owner;
            end

            // A response that arrives after its timeout belongs to nobody.
            if (w_set_orphan) begin
                r_orphan <= 1'b1;
            end else if (r_orphan && mem_valid) begin
                r_orphan <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: per-cycle vector table plus
// hand-written streak, timeout/orphan and reset sequences.
module tb_mem_port_arbiter;

    typedef struct packed {
        logic        ireq;
        logic [31:0] iaddr;
        logic        dreq;
        logic        dwe;
        logic [31:0] daddr;
        logic [31:0] dwdata;
        logic [3:0]  dwstrb;
        logic        mrdy;
        logic        mval;
        logic [31:0] mrdata;
    } in_t;

    typedef struct packed {
        logic        irdy;
        logic        ival;
        logic [31:0] irdata;
        logic        ierr;
        logic        drdy;
        logic        dval;
        logic [31:0] drdata;
        logic        derr;
        logic        mreq;
        logic        mwe;
        logic [31:0] maddr;
        logic [31:0] mwdata;
        logic [3:0]  mwstrb;
    } out_t;

    typedef struct packed {
        in_t  i;
        out_t o;
    } vec_t;

    localparam logic        Y = 1'b1;
    localparam logic        N = 1'b0;
    localparam logic [31:0] Z = 32'h0;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req, inst_ready, inst_valid, inst_err;
    logic [31:0] inst_addr, inst_rdata;
    logic        data_req, data_we, data_ready, data_valid, data_err;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic [3:0]  data_wstrb;
    logic        mem_req, mem_we, mem_ready, mem_valid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    int n_checks = 0;
    int n_errors = 0;
    int n_overlap = 0;
    int n_proto = 0;
    logic pend_i, pend_d;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .TIMEOUT         (8),
        .DATA_STREAK_MAX (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .inst_req   (inst_req),
        .inst_addr  (inst_addr),
        .inst_ready (inst_ready),
        .inst_valid (inst_valid),
        .inst_rdata (inst_rdata),
        .inst_err   (inst_err),
        .data_req   (data_req),
        .data_we    (data_we),
        .data_addr  (data_addr),
        .data_wdata (data_wdata),
        .data_wstrb (data_wstrb),
        .data_ready (data_ready),
        .data_valid (data_valid),
        .data_rdata (data_rdata),
        .data_err   (data_err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_ready  (mem_ready),
        .mem_valid  (mem_valid),
        .mem_rdata  (mem_rdata)
    );

    // Requesters must hold *_req until *_ready.
    always @(posedge clk) begin
        if (reset) begin
            pend_i <= 1'b0;
            pend_d <= 1'b0;
        end else begin
            if (pend_i && !inst_req) begin
                n_proto++;
                $display("FAIL req_hold: inst_req dropped before inst_ready at %0t", $time);
            end
            if (pend_d && !data_req) begin
                n_proto++;
                $display("FAIL req_hold: data_req dropped before data_ready at %0t", $time);
            end
            pend_i <= inst_req && !inst_ready;
            pend_d <= data_req && !data_ready;
        end
    end

    always @(negedge clk) begin
        if ((inst_valid && data_valid) || (inst_valid && inst_ready) || (data_valid && data_ready)) begin
            n_overlap++;
            $display("FAIL overlap: illegal valid/ready combination at %0t", $time);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic in_t fi(input logic ireq, input logic [31:0] iaddr, input logic dreq,
                               input logic dwe, input logic [31:0] daddr, input logic [31:0] dwdata,
                               input logic [3:0] dwstrb, input logic mrdy, input logic mval,
                               input logic [31:0] mrdata);
        return '{ireq, iaddr, dreq, dwe, daddr, dwdata, dwstrb, mrdy, mval, mrdata};
    endfunction

    function automatic out_t fo(input logic irdy, input logic ival, input logic [31:0] irdata,
                                input logic ierr, input logic drdy, input logic dval,
                                input logic [31:0] drdata, input logic derr, input logic mreq,
                                input logic mwe, input logic [31:0] maddr, input logic [31:0] mwdata,
                                input logic [3:0] mwstrb);
        return '{irdy, ival, irdata, ierr, drdy, dval, drdata, derr, mreq, mwe, maddr, mwdata, mwstrb};
    endfunction

    function automatic out_t snap();
        return '{inst_ready, inst_valid, inst_rdata, inst_err, data_ready, data_valid, data_rdata,
                 data_err, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb};
    endfunction

    task automatic apply(input in_t v);
        inst_req   = v.ireq;
        inst_addr  = v.iaddr;
        data_req   = v.dreq;
        data_we    = v.dwe;
        data_addr  = v.daddr;
        data_wdata = v.dwdata;
        data_wstrb = v.dwstrb;
        mem_ready  = v.mrdy;
        mem_valid  = v.mval;
        mem_rdata  = v.mrdata;
    endtask

    task automatic clr();
        apply(fi(N, Z, N, N, Z, Z, 4'h0, N, N, Z));
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[$];
    in_t  idle_in;
    out_t zero_out;
    out_t act_o;
    out_t exp_o;
    int   n_dgrant, n_iv, n_dv, n_dr;
    logic got;

    initial begin
        idle_in  = fi(N, Z, N, N, Z, Z, 4'h0, N, N, Z);
        zero_out = fo(N, N, Z, N, N, N, Z, N, N, N, Z, Z, 4'h0);

        // single fetch at 0x100: ready immediately, response 3 cycles later
        tbl.push_back('{fi(Y, 32'h100, N, N, Z, Z, 4'h0, N, N, Z), fo(Y, N, Z, N, N, N, Z, N, N, N, Z, Z, 4'h0)});
        tbl.push_back('{fi(N, Z, N, N, Z, Z, 4'h0, Y, N, Z),       fo(N, N, Z, N, N, N, Z, N, Y, N, 32'h100, Z, 4'h0)});
        tbl.push_back('{idle_in, zero_out});
        tbl.push_back('{idle_in, zero_out});
        tbl.push_back('{fi(N, Z, N, N, Z, Z, 4'h0, N, Y, 32'h13),  fo(N, Y, 32'h13, N, N, N, Z, N, N, N, Z, Z, 4'h0)});
        tbl.push_back('{idle_in, zero_out});
        // store with zero-latency memory: rdata forced to 0
        tbl.push_back('{fi(N, Z, Y, Y, 32'h3004, 32'hDEADBEEF, 4'hF, N, N, Z), fo(N, N, Z, N, Y, N, Z, N, N, N, Z, Z, 4'h0)});
        tbl.push_back('{fi(N, Z, N, N, Z, Z, 4'h0, Y, Y, 32'h12345678),
                        fo(N, N, Z, N, N, Y, Z, N, Y, Y, 32'h3004, 32'hDEADBEEF, 4'hF)});
        tbl.push_back('{idle_in, zero_out});
        // misaligned fetch: error next cycle, no memory access
        tbl.push_back('{fi(Y, 32'h102, N, N, Z, Z, 4'h0, N, N, Z), fo(Y, N, Z, N, N, N, Z, N, N, N, Z, Z, 4'h0)});
        tbl.push_back('{idle_in, fo(N, Y, Z, Y, N, N, Z, N, N, N, Z, Z, 4'h0)});
        tbl.push_back('{idle_in, zero_out});
        // misaligned fetch, data granted during the error cycle
        tbl.push_back('{fi(Y, 32'h206, N, N, Z, Z, 4'h0, N, N, Z), fo(Y, N, Z, N, N, N, Z, N, N, N, Z, Z, 4'h0)});
        tbl.push_back('{fi(N, Z, Y, N, 32'h2000, Z, 4'h0, N, N, Z), fo(N, Y, Z, Y, Y, N, Z, N, N, N, Z, Z, 4'h0)});
        tbl.push_back('{fi(N, Z, N, N, Z, Z, 4'h0, Y, N, Z),        fo(N, N, Z, N, N, N, Z, N, Y, N, 32'h2000, Z, 4'h0)});
        tbl.push_back('{fi(N, Z, N, N, Z, Z, 4'h0, N, Y, 32'hCAFEF00D), fo(N, N, Z, N, N, Y, 32'hCAFEF00D, N, N, N, Z, Z, 4'h0)});
        tbl.push_back('{idle_in, zero_out});
        // contention: data first, inst in the IDLE cycle after data_valid
        tbl.push_back('{fi(Y, 32'h104, Y, N, 32'h2000, Z, 4'h0, N, N, Z), fo(N, N, Z, N, Y, N, Z, N, N, N, Z, Z, 4'h0)});
        tbl.push_back('{fi(Y, 32'h104, N, N, Z, Z, 4'h0, Y, N, Z),        fo(N, N, Z, N, N, N, Z, N, Y, N, 32'h2000, Z, 4'h0)});
        tbl.push_back('{fi(Y, 32'h104, N, N, Z, Z, 4'h0, N, Y, 32'hA5A5A5A5), fo(N, N, Z, N, N, Y, 32'hA5A5A5A5, N, N, N, Z, Z, 4'h0)});
        tbl.push_back('{fi(Y, 32'h104, N, N, Z, Z, 4'h0, N, N, Z),        fo(Y, N, Z, N, N, N, Z, N, N, N, Z, Z, 4'h0)});
        tbl.push_back('{fi(N, Z, N, N, Z, Z, 4'h0, Y, Y, 32'h93),         fo(N, Y, 32'h93, N, N, N, Z, N, Y, N, 32'h104, Z, 4'h0)});
        tbl.push_back('{idle_in, zero_out});

        reset = 1'b1;
        clr();
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", snap(), zero_out);
        reset = 1'b0;

        for (int k = 0; k < tbl.size(); k++) begin
            apply(tbl[k].i);
            @(negedge clk);
            act_o = snap();
            exp_o = tbl[k].o;
            if (!exp_o.mreq) begin
                act_o.mwe    = 1'b0;
                act_o.maddr  = '0;
                act_o.mwdata = '0;
                act_o.mwstrb = '0;
            end
            check($sformatf("vec%0d", k), act_o, exp_o);
            next_cycle();
        end

        // streak: both held, inst must be forced after exactly 4 data grants
        clr();
        inst_req  = 1'b1;
        inst_addr = 32'h200;
        data_req  = 1'b1;
        data_addr = 32'h2400;
        n_dgrant  = 0;
        got       = 1'b0;
        for (int c = 0; c < 60 && !got; c++) begin
            mem_ready = mem_req;
            mem_valid = mem_req;
            mem_rdata = 32'h0000_0517;
            @(negedge clk);
            if (data_ready) n_dgrant++;
            if (inst_ready) got = 1'b1;
            next_cycle();
        end
        inst_req = 1'b0;
        check("streak_inst_forced", got, 1);
        check("streak_data_grants", n_dgrant, 4);
        n_iv = 0;
        n_dv = 0;
        n_dr = 0;
        for (int c = 0; c < 6; c++) begin
            mem_ready = mem_req;
            mem_valid = mem_req;
            @(negedge clk);
            if (inst_valid) begin
                n_iv++;
                check("streak_inst_rdata", {inst_err, inst_rdata}, {1'b0, 32'h0000_0517});
            end
            if (data_valid) n_dv++;
            if (data_ready) n_dr++;
            next_cycle();
            if (n_dr != 0) data_req = 1'b0;
        end
        check("streak_inst_resp", n_iv, 1);
        check("streak_data_regrant", n_dr, 1);
        check("streak_data_resp", n_dv, 1);
        clr();

        // timeout in WAIT with TIMEOUT=8, then a late orphan response
        inst_req  = 1'b1;
        inst_addr = 32'h300;
        @(negedge clk);
        check("to_grant", inst_ready, 1);
        next_cycle();
        inst_req  = 1'b0;
        mem_ready = 1'b1;
        @(negedge clk);
        check("to_issue", mem_req, 1);
        next_cycle();
        mem_ready = 1'b0;
        for (int c = 1; c < 8; c++) begin
            @(negedge clk);
            check($sformatf("to_wait%0d", c), {mem_req, inst_valid, data_valid}, 3'b000);
            next_cycle();
        end
        @(negedge clk);
        check("to_err_resp", {inst_valid, inst_err, inst_rdata, data_valid}, {1'b1, 1'b1, 32'h0, 1'b0});
        next_cycle();
        data_req  = 1'b1;
        data_addr = 32'h2800;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check($sformatf("orphan_block%0d", c), data_ready, 0);
            next_cycle();
        end
        mem_valid = 1'b1;
        mem_rdata = 32'hBAD0BAD0;
        @(negedge clk);
        check("orphan_drop", {data_ready, data_valid, inst_valid}, 3'b000);
        next_cycle();
        mem_valid = 1'b0;
        @(negedge clk);
        check("orphan_cleared_grant", data_ready, 1);
        next_cycle();
        data_req  = 1'b0;
        mem_ready = 1'b1;
        mem_valid = 1'b1;
        mem_rdata = 32'h11112222;
        @(negedge clk);
        check("post_orphan_load", {data_valid, data_err, data_rdata}, {1'b1, 1'b0, 32'h11112222});
        next_cycle();
        clr();

        // reset asserted in WAIT, then a fresh fetch
        inst_req  = 1'b1;
        inst_addr = 32'h400;
        @(negedge clk);
        check("rst_grant", inst_ready, 1);
        next_cycle();
        inst_req  = 1'b0;
        mem_ready = 1'b1;
        next_cycle();
        mem_ready = 1'b0;
        #1;
        check("rst_pre_addr", mem_addr, 32'h400);
        reset    = 1'b1;
        data_req = 1'b1;
        #1;
        check("rst_async_outputs", snap(), zero_out);
        next_cycle();
        reset     = 1'b0;
        data_req  = 1'b0;
        inst_req  = 1'b1;
        inst_addr = 32'h408;
        @(negedge clk);
        check("rst_fresh_grant", {inst_ready, mem_req}, 2'b10);
        next_cycle();
        inst_req  = 1'b0;
        mem_ready = 1'b1;
        mem_valid = 1'b1;
        mem_rdata = 32'h00500093;
        @(negedge clk);
        check("rst_fresh_resp", {inst_valid, inst_err, inst_rdata, mem_req, mem_addr},
              {1'b1, 1'b0, 32'h00500093, 1'b1, 32'h408});
        next_cycle();
        clr();
        @(negedge clk);
        check("rst_fresh_idle", {inst_valid, mem_req}, 2'b00);

        check("no_overlap", n_overlap, 0);
        check("req_protocol", n_proto, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
